// File: rtl/filter_delay_aligner.sv
// Controller/reader for the filter delay line: hides startup latency and flushes the tail so each line leaves group-delay aligned.
// Optional in_last framing check is enabled with FILTER_DELAY_ALIGNER_LAST_CHECK_EN.
module filter_delay_aligner #(
    parameter int unsigned pDataLength  = 16,
    parameter int unsigned pDelayLength = 4,
    parameter int unsigned pLineLength  = 8,
    parameter int unsigned pCountLength = 4
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [pDataLength-1:0] in_data,
    output logic                   fir_enable,
    output logic                   fir_clear,
    output logic [pDataLength-1:0] fir_in,
    input  logic [pDataLength-1:0] fir_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [pDataLength-1:0] out_data,
`ifdef FILTER_DELAY_ALIGNER_LAST_CHECK_EN
    input  logic                   in_last,
    output logic                   err_line,
`endif
    output logic                   out_last
);

    localparam int unsigned LATENCY = pDelayLength - 1;
    localparam logic [pCountLength-1:0] FILL_END   = pCountLength'(LATENCY - 1);
    localparam logic [pCountLength-1:0] STREAM_END = pCountLength'(pLineLength - 1);
    localparam logic [pCountLength-1:0] FLUSH_END  = pCountLength'(pLineLength + LATENCY - 1);
    localparam logic [pCountLength-1:0] LAST_IDX   = pCountLength'(pLineLength - 1);

    typedef enum logic [2:0] {
        PRIME  = 3'd0,
        FILL   = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t                  r_state;
    logic [pCountLength-1:0] r_push_cnt;
    logic [pCountLength-1:0] r_out_cnt;
    logic                    r_out_valid;

    logic                   w_can_out;
    logic                   w_push;
    logic                   w_in_ready;
    logic [pDataLength-1:0] w_fir_in;
    logic                   w_produce;
    logic                   w_out_hs;
    logic                   w_out_last;

    // Push/accept decode; clear suppresses all handshakes in the cycle it is asserted.
    always_comb begin
        w_can_out  = !r_out_valid || out_ready;
        w_push     = 1'b0;
        w_in_ready = 1'b0;
        w_fir_in   = '0;
        if (!clear) begin
            case (r_state)
                FILL: begin
                    w_in_ready = 1'b1;
                    w_push     = in_valid;
                    w_fir_in   = in_data;
                end
                STREAM: begin
                    w_in_ready = w_can_out;
                    w_push     = in_valid && w_can_out;
                    w_fir_in   = in_data;
                end
                FLUSH: begin
                    w_push = w_can_out;
                end
                default: ;
            endcase
        end
        w_produce  = w_push && ((r_state == STREAM) || (r_state == FLUSH));
        w_out_hs   = r_out_valid && out_ready;
        w_out_last = r_out_valid && (r_out_cnt == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= PRIME;
            r_push_cnt  <= '0;
            r_out_cnt   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_push_cnt <= r_push_cnt + pCountLength'(1);
            end
            if (w_out_hs) begin
                r_out_cnt <= r_out_cnt + pCountLength'(1);
            end
            case (r_state)
                PRIME: begin
                    r_state    <= FILL;
                    r_push_cnt <= '0;
                    r_out_cnt  <= '0;
                end
                FILL: begin
                    if (w_push && (r_push_cnt == FILL_END)) r_state <= STREAM;
                end
                STREAM: begin
                    if (w_push && (r_push_cnt == STREAM_END)) r_state <= FLUSH;
                end
                FLUSH: begin
                    if (w_push && (r_push_cnt == FLUSH_END)) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_out_hs && w_out_last) r_state <= PRIME;
                end
                default: r_state <= PRIME;
            endcase
            // A push in the same cycle as a handshake keeps the output valid with new data.
            if (w_produce) begin
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef FILTER_DELAY_ALIGNER_LAST_CHECK_EN
    logic r_err_line;
    logic w_accept;

    assign w_accept = in_valid && w_in_ready;

    // Sticky framing error: in_last must coincide exactly with the final sample of a line.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_err_line <= 1'b0;
        end else if (w_accept && (in_last != (r_push_cnt == LAST_IDX))) begin
            r_err_line <= 1'b1;
        end
    end

    assign err_line = r_err_line;
`endif

    assign in_ready   = w_in_ready;
    assign fir_enable = w_push;
    assign fir_clear  = clear || (r_state == PRIME);
    assign fir_in     = w_fir_in;
    assign out_valid  = r_out_valid;
    assign out_data   = fir_out;
    assign out_last   = w_out_last;

endmodule

// File: doc/filter_delay_aligner.md
Name: filter_delay_aligner

Overview:
- Controller and reader for the filter delay line (FIR stand-in).
- Drives the delay line's enable, clear and input, and consumes its output.
- Discards the delay line's startup latency and flushes the tail with zeros, so each projection line of filtered samples leaves as exactly pLineLength group-delay-aligned samples.
- Sits between the filter input stream and the back-projection sample consumer; valid/ready on both sides.

Parameters:
- pDataLength, 16: width of a filtered sample.
- pDelayLength, 4: delay line length (filter order / 2). Latency L = pDelayLength-1 enables. Legal range >= 2.
- pLineLength, 8: samples per projection line. Legal range >= pDelayLength.
- pCountLength, 4: counter width; must hold pLineLength+pDelayLength.

Ports:
- clk  input  1  clock, rising edge
- clear  input  1  synchronous active-high reset
- in_valid  input  1  upstream sample valid
- in_ready  output  1  upstream sample accepted when in_valid && in_ready
- in_data  input  pDataLength  upstream sample
- fir_enable  output  1  delay-line advance strobe
- fir_clear  output  1  delay-line synchronous clear
- fir_in  output  pDataLength  sample pushed into the delay line
- fir_out  input  pDataLength  delay-line registered output
- out_valid  output  1  aligned sample valid
- out_ready  input  1  downstream accept
- out_data  output  pDataLength  aligned sample
- out_last  output  1  marks the final sample of a line

Behaviour:
- Reset (clear high): state=PRIME; push_cnt=0, out_cnt=0; out_valid=0, out_last=0, in_ready=0, fir_enable=0; fir_clear=1.
- Definitions:
  - can_out = !out_valid || out_ready.
  - push = fir_enable.
  - push_cnt counts pushes in the current line; out_cnt counts output handshakes.
- FSM states:
  - PRIME: fir_clear=1 for one cycle, then FILL.
  - FILL: in_ready=1; push = in_valid; fir_in=in_data. No outputs are produced (the delay line still emits cleared zeros). When push_cnt reaches L after a push, go to STREAM.
  - STREAM: in_ready=can_out; push = in_valid && can_out; fir_in=in_data. Each push produces one output. When push_cnt reaches pLineLength after a push, go to FLUSH.
  - FLUSH: in_ready=0; push = can_out; fir_in=0. Each push produces one output. When push_cnt reaches pLineLength+L after a push, go to DRAIN.
  - DRAIN: no pushes. Wait for the handshake where out_last=1, then go to PRIME.
- Output stage:
  - out_valid is set the cycle after a producing push.
  - out_valid is cleared on out_valid && out_ready with no producing push in the same cycle.
  - A simultaneous handshake and push keep out_valid=1 and present the new data.
  - out_data = fir_out (passthrough). The delay line holds fir_out while not enabled, so out_data is stable under stall.
- Alignment and latency:
  - Input sample i is accepted on push i and appears on out_data the cycle after push i+L.
  - Output k equals input k for k = 0..pLineLength-1.
- out_last=1 together with out_valid when out_cnt == pLineLength-1; otherwise 0.
- Backpressure:
  - out_ready low with out_valid high stalls all pushes in STREAM/FLUSH.
  - in_ready drops the same cycle (combinational from out_ready).
- Gaps: in_valid low in FILL or STREAM inserts no push; timing only, alignment preserved.
- Clear mid-line: all in-flight data is dropped; out_valid falls next cycle; FSM restarts from PRIME. No partial out_last is emitted.
- Back-to-back lines: the first sample of the next line is accepted at the earliest the cycle after PRIME. Line-to-line gap is at least 2 cycles (DRAIN exit, PRIME).

Optional Feature:
- Macro: FILTER_DELAY_ALIGNER_LAST_CHECK_EN.
- When defined:
  - Adds input in_last (1) and output err_line (1, sticky, reset 0 by clear).
  - err_line sets if an accepted sample has in_last=1 while push_cnt != pLineLength-1.
  - err_line also sets if the pLineLength-th accepted sample has in_last=0.
  - Datapath behaviour is unchanged.
- When undefined: neither port exists; in_last is not checked.

Test Plan:
- Defaults (D=4, L=3, N=8); input 1..8 back-to-back; out_ready=1 -> fir_enable high 11 cycles; outputs 1..8 in order; out_last only on 8; no zeros emitted; FSM returns to PRIME.
- Same stimulus, out_ready low for 5 cycles after the second output -> out_data holds 2 throughout; in_ready=0 during stall; sequence resumes 3..8 with nothing lost or duplicated.
- in_valid toggling every other cycle during FILL and STREAM -> output sequence still 1..8; push count still 11.
- clear asserted after 5 accepted samples, then a new line 11..18 -> out_valid=0 cycle after clear; fir_clear pulses; outputs exactly 11..18 with no residue from the first line.
- Two lines back-to-back (1..8, then 21..28) with continuous in_valid -> 16 outputs, out_last on 8 and 28; next line accepted two cycles after the line-1 out_last handshake.
- With FILTER_DELAY_ALIGNER_LAST_CHECK_EN: in_last on sample 6 -> err_line=1 and stays 1 until clear; with in_last on sample 8 -> err_line stays 0.
